// File: rtl/sub_serial_nbit.sv
// Bit-serial subtractor: O = A - B - Bin over WIDTH bits, one bit per clock, LSB first,
// through a single full-subtractor cell with operands and results on valid/ready handshakes.
module sub_serial_nbit #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O,
  output logic             Borrow,
  output logic             Overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-2:0] sh;
  logic [CNT_W-1:0] cnt;
  logic             br;

  logic             a_i;
  logic             b_i;
  logic             d_i;
  logic             br_next;
  logic             last;
  logic [WIDTH-1:0] sh_next;

  assign a_i     = a_q[cnt];
  assign b_i     = b_q[cnt];
  assign d_i     = a_i ^ b_i ^ br;
  assign br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br);
  assign last    = (cnt == CNT_W'(WIDTH - 1));
  // The new bit enters at the MSB; the partial register keeps only the upper WIDTH-1 bits
  // because the final bit is merged straight into O on the last step.
  assign sh_next = {d_i, sh};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      O         <= '0;
      Borrow    <= 1'b0;
      Overflow  <= 1'b0;
      cnt       <= '0;
      br        <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sh        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= A;
            b_q      <= B;
            br       <= Bin;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sh <= sh_next[WIDTH-1:1];
          br <= br_next;
          if (last) begin
            // Visible results only change here, so they hold across the idle gap.
            O         <= sh_next;
            Borrow    <= br_next;
            Overflow  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_i != a_q[WIDTH-1]);
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
